// File: rtl/ttc3_dus_access_arbiter.sv
// ttc3_dus_access_arbiter
// Shares the single DUS storage KDF read port between NUM_CLIENTS requesters.
// Grants are round-robin over (req & client_enable), bounded to MAX_HOLD
// cycles, and every grant is followed by a SCRUB_CYCLES gap with kdf_request
// forced low so no two owners see adjacent DUS exposure windows.
module ttc3_dus_access_arbiter #(
  parameter int unsigned NUM_CLIENTS  = 4,
  parameter int unsigned MAX_HOLD     = 16,
  parameter int unsigned SCRUB_CYCLES = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           dus_valid,
  input  logic [NUM_CLIENTS-1:0]         client_enable,
  input  logic [NUM_CLIENTS-1:0]         req,
  input  logic [NUM_CLIENTS-1:0]         done,
  output logic [NUM_CLIENTS-1:0]         grant,
  output logic [$clog2(NUM_CLIENTS)-1:0] grant_id,
  output logic                           kdf_request,
  output logic                           busy,
  output logic                           timeout
);

  localparam int unsigned IDW = $clog2(NUM_CLIENTS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_SCRUB
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_CLIENTS-1:0] grant_q, grant_d;
  logic [IDW-1:0]         grant_id_q, grant_id_d;
  logic                   kdf_request_q, kdf_request_d;
  logic                   timeout_q, timeout_d;
  logic [7:0]             hold_q, hold_d;
  logic [3:0]             scrub_q, scrub_d;
  logic [IDW-1:0]         rr_q, rr_d;

  logic [NUM_CLIENTS-1:0] eligible;
  logic                   pick_found;
  logic [IDW-1:0]         pick_idx;
  logic [IDW-1:0]         pick_next;
  int unsigned            cand;
  logic                   owner_release;

  assign eligible = req & client_enable;

  // Round-robin search: first eligible index starting at the rr pointer, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      cand = (32'(rr_q) + i) % NUM_CLIENTS;
      if (!pick_found && eligible[cand[IDW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IDW-1:0];
      end
    end
    pick_next = IDW'((32'(pick_idx) + 1) % NUM_CLIENTS);
  end

  // Owner-side release conditions; these take priority over the hold limit.
  assign owner_release = !dus_valid || !req[grant_id_q] || done[grant_id_q] ||
                         !client_enable[grant_id_q];

  // Next-state and registered-output computation.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_id_d    = grant_id_q;
    kdf_request_d = kdf_request_q;
    timeout_d     = 1'b0;
    hold_d        = hold_q;
    scrub_d       = scrub_q;
    rr_d          = rr_q;
    case (state_q)
      ST_IDLE: begin
        if (dus_valid && pick_found) begin
          state_d           = ST_GRANT;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          grant_id_d        = pick_idx;
          kdf_request_d     = 1'b1;
          hold_d            = 8'd1;
          rr_d              = pick_next;
        end
      end
      ST_GRANT: begin
        if (owner_release || (hold_q == 8'(MAX_HOLD))) begin
          // A release in the same cycle as hold expiry is a normal release.
          timeout_d     = !owner_release;
          state_d       = ST_SCRUB;
          grant_d       = '0;
          grant_id_d    = '0;
          kdf_request_d = 1'b0;
          hold_d        = '0;
          scrub_d       = 4'd1;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      ST_SCRUB: begin
        if (scrub_q == 4'(SCRUB_CYCLES)) begin
          state_d = ST_IDLE;
          scrub_d = '0;
        end else begin
          scrub_d = scrub_q + 4'd1;
        end
      end
      default: begin
        state_d       = ST_IDLE;
        grant_d       = '0;
        grant_id_d    = '0;
        kdf_request_d = 1'b0;
        hold_d        = '0;
        scrub_d       = '0;
      end
    endcase
  end

  // State register with synchronous reset; reset drops any live grant at once.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      grant_id_q    <= '0;
      kdf_request_q <= 1'b0;
      timeout_q     <= 1'b0;
      hold_q        <= '0;
      scrub_q       <= '0;
      rr_q          <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_id_q    <= grant_id_d;
      kdf_request_q <= kdf_request_d;
      timeout_q     <= timeout_d;
      hold_q        <= hold_d;
      scrub_q       <= scrub_d;
      rr_q          <= rr_d;
    end
  end

  assign grant       = grant_q;
  assign grant_id    = grant_id_q;
  assign kdf_request = kdf_request_q;
  assign busy        = (state_q != ST_IDLE);
  assign timeout     = timeout_q;

endmodule

// File: doc/ttc3_dus_access_arbiter.md
Name: ttc3_dus_access_arbiter

Overview:
- Sequences and shares the single DUS storage KDF read port (kdf_request/kdf_dus) between NUM_CLIENTS requesters, such as KDF engines or attestation units.
- Grants access one client at a time, in round-robin order, under a static enable mask.
- Each grant is time-bounded; a forced scrub gap follows every grant so no two clients see adjacent DUS exposure windows.
- Sits between the client datapaths and ttc3_dus_storage; it owns kdf_request.

Parameters:
- NUM_CLIENTS, 4, number of requesters (2..8).
- MAX_HOLD, 16, maximum consecutive cycles a grant may be held (1..255).
- SCRUB_CYCLES, 2, cycles kdf_request is forced low after every grant (1..15).

Ports:
- clock, input, 1, single system clock; all logic on posedge.
- reset, input, 1, synchronous active-high reset.
- dus_valid, input, 1, DUS-valid flag from ttc3_dus_storage.
- client_enable, input, NUM_CLIENTS, per-client permission mask; disabled clients are never granted.
- req, input, NUM_CLIENTS, level request per client; held until grant or abandoned.
- done, input, NUM_CLIENTS, owner asserts for ≥1 cycle to release its grant.
- grant, output, NUM_CLIENTS, registered, one-hot or zero; owner may sample kdf_dus while its bit is high.
- grant_id, output, $clog2(NUM_CLIENTS), index of current owner; 0 when idle.
- kdf_request, output, 1, registered; drives ttc3_dus_storage.kdf_request; high iff grant != 0.
- busy, output, 1, high in GRANT or SCRUB.
- timeout, output, 1, one-cycle pulse when a grant is revoked by MAX_HOLD expiry.

Behaviour:
- Reset, synchronous, checked at posedge:
  - state=IDLE; grant=0, grant_id=0, kdf_request=0, busy=0, timeout=0.
  - hold counter=0, scrub counter=0.
  - rr pointer=0, so client 0 has first priority after reset.
  - Reset asserted mid-grant drops grant/kdf_request at that same edge.
- Eligible set: req & client_enable.
- IDLE:
  - If dus_valid=1 and the eligible set is nonzero, pick the first eligible index searching rr, rr+1, …, wrapping modulo NUM_CLIENTS.
  - At the next edge: state=GRANT, grant[k]=1, grant_id=k, kdf_request=1, busy=1, hold=1, rr=(k+1) mod NUM_CLIENTS.
  - Latency from req high to grant high: exactly 1 cycle.
  - If dus_valid=0, nothing is granted and req is simply held pending.
- GRANT:
  - The following are evaluated each cycle, in priority order.
  - (a) If dus_valid=0, or req[k]=0, or done[k]=1, or client_enable[k]=0 → SCRUB at the next edge.
  - (b) Else if hold==MAX_HOLD → SCRUB at the next edge and timeout=1 for that one cycle.
  - (c) Else hold++.
  - Result: grant is high for at most MAX_HOLD cycles.
  - On entering SCRUB: grant=0, grant_id=0, kdf_request=0, scrub=1, busy remains 1.
  - Requests from other clients during GRANT are ignored, never preempted.
- SCRUB:
  - kdf_request is held 0 for exactly SCRUB_CYCLES cycles.
  - When scrub==SCRUB_CYCLES → IDLE at the next edge (busy=0); else scrub++.
  - Arbitration resumes in IDLE, so the minimum gap between two grants is SCRUB_CYCLES+1 cycles: SCRUB_CYCLES in SCRUB plus one IDLE decision cycle.
- Invariants checked by the bench:
  - grant is one-hot or zero.
  - kdf_request == |grant.
  - No grant bit ever rises while dus_valid=0.
  - No grant to a client whose client_enable bit is 0.
- Done or req changes by non-owners have no effect.
- Simultaneous done[k] and hold==MAX_HOLD: normal release, timeout=0.

Test Plan:
- Reset, write the DUS so dus_valid=1, then req=4'b0001 and release with done[0] on the 3rd grant cycle → grant=0001 and kdf_request=1 one cycle after req; grant high 3 cycles; then 2 cycles kdf_request=0; busy falls 1 cycle later; timeout=0.
- req=4'b1111 held continuously with each owner asserting done on its 1st grant cycle → grant order 0,1,2,3,0; each grant 1 cycle; kdf_request low ≥2 cycles between grants; grant_id matches each grant.
- req=4'b0100 held with done never asserted → grant=0100 for exactly 16 cycles; timeout pulses exactly 1 cycle at revocation; then SCRUB, IDLE, and client 2 is re-granted.
- dus_valid=0 (before any DUS write) with req=4'b0011 for 20 cycles → grant=0, kdf_request=0 throughout; after dus_valid rises, grant=0001 within 1 cycle.
- client_enable=4'b1101 with req=4'b0010 → never granted; then req=4'b1010 → only client 3 is granted; clearing client_enable[3] mid-grant → grant drops next edge.
- reset asserted on the 5th cycle of a grant → grant, kdf_request, busy and grant_id are 0 at that edge; after release, req=4'b1000 with req[0]=1 also set → client 0 is granted first (rr reset to 0).
